// File: rtl/cordic_multi_if.sv
// rtl/cordic_multi_if.sv - request/result handshake and atan LUT port of the CORDIC engine
interface cordic_multi_if #(
    parameter int IW       = 32,
    parameter int OUT_FRAC = 10,
    parameter int AW       = 4
);
    localparam int OUT_W = OUT_FRAC + 2;

    logic                    start;
    logic                    mode;
    logic [8:0]              degree;
    logic signed [OUT_W-1:0] x_in;
    logic signed [OUT_W-1:0] y_in;
    logic                    busy;
    logic                    done;
    logic signed [OUT_W+1:0] res_a;
    logic signed [OUT_W+1:0] res_b;
    logic [15:0]             ang_out;
    logic [AW-1:0]           addr;
    logic signed [IW-1:0]    dout;

    modport master (
        output start, mode, degree, x_in, y_in, dout,
        input  busy, done, res_a, res_b, ang_out, addr
    );

    modport slave (
        input  start, mode, degree, x_in, y_in, dout,
        output busy, done, res_a, res_b, ang_out, addr
    );
endinterface

// File: rtl/cordic_multi.sv
// rtl/cordic_multi.sv - iterative rotation/vectoring CORDIC using an external atan LUT
// Define CORDIC_GAIN_COMP_EN to scale the vectoring magnitude by 1/K.
module cordic_multi #(
    parameter int ITER     = 16,
    parameter int IW       = 32,
    parameter int OUT_FRAC = 10,
    parameter int AW       = $clog2(ITER)
) (
    input  logic          clk,
    input  logic          rst,
    cordic_multi_if.slave bus
);
    localparam int OUT_W = OUT_FRAC + 2;
    localparam int RW    = OUT_W + 2;
    localparam int FB    = IW - 4;
    localparam int ZF    = IW - 10;
    localparam int SH    = FB - OUT_FRAC;
    localparam int ASH   = ZF - 7;

    localparam logic signed [IW-1:0] INV_K    = IW'($rtoi(0.6072529350088813 * (2.0 ** FB) + 0.5));
    localparam logic signed [IW-1:0] D180     = IW'(180) <<< ZF;
    localparam logic signed [IW-1:0] D360     = IW'(360) <<< ZF;
    localparam logic signed [IW:0]   RES_MAX  = (IW+1)'((2 ** (RW - 1)) - 1);
    localparam logic signed [IW:0]   RES_MIN  = (IW+1)'(-(2 ** (RW - 1)));
    localparam logic signed [IW:0]   ANG_WRAP = (IW+1)'(360 * 128);
    localparam logic [AW-1:0]        LAST     = AW'(ITER - 1);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_POST} state_t;

    state_t                  state_q, state_d;
    logic                    mode_q, mode_d, neg_q, neg_d, ph_q, ph_d;
    logic                    busy_q, busy_d, done_q, done_d;
    logic [8:0]              deg_q, deg_d;
    logic signed [OUT_W-1:0] xi_q, xi_d, yi_q, yi_d;
    logic signed [IW-1:0]    x_q, x_d, y_q, y_d, z_q, z_d;
    logic [AW-1:0]           i_q, i_d;
    logic signed [RW-1:0]    res_a_q, res_a_d, res_b_q, res_b_d;
    logic [15:0]             ang_q, ang_d;

    logic [8:0]              deg_eff;
    logic signed [10:0]      zdeg;
    logic                    neg_rot, s_pos;
    logic signed [IW-1:0]    xv, yv, xs, ys, ang_sum;
    logic signed [IW:0]      rz;

    // Round-to-nearest-even of v dropping sh fraction bits; one extra bit absorbs the carry.
    function automatic logic signed [IW:0] rne(input logic signed [IW-1:0] v, input int sh);
        logic signed [IW-1:0] t;
        logic [IW-1:0]        frac, half;
        t    = v >>> sh;
        frac = v & ~({IW{1'b1}} << sh);
        half = {{(IW-1){1'b0}}, 1'b1} << (sh - 1);
        return {t[IW-1], t} + {{IW{1'b0}}, (frac > half) || ((frac == half) && t[0])};
    endfunction

    function automatic logic signed [RW-1:0] sat(input logic signed [IW:0] r);
        if (r > RES_MAX) return RES_MAX[RW-1:0];
        if (r < RES_MIN) return RES_MIN[RW-1:0];
        return r[RW-1:0];
    endfunction

`ifdef CORDIC_GAIN_COMP_EN
    logic signed [IW-1:0] mag_comp;

    always_comb begin
        mag_comp = '0;
        for (int k = 1; k <= FB; k++) begin
            if (INV_K[FB-k]) mag_comp = mag_comp + (x_q >>> k);
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        neg_d   = neg_q;
        ph_d    = ph_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        deg_d   = deg_q;
        xi_d    = xi_q;
        yi_d    = yi_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        res_a_d = res_a_q;
        res_b_d = res_b_q;
        ang_d   = ang_q;

        // Fold the full circle into [-90, 90] so the CORDIC convergence range covers it.
        deg_eff = (deg_q >= 9'd360) ? deg_q - 9'd360 : deg_q;
        zdeg    = $signed({2'b00, deg_eff});
        neg_rot = 1'b0;
        if (deg_eff > 9'd90 && deg_eff <= 9'd270) begin
            zdeg    = zdeg - 11'sd180;
            neg_rot = 1'b1;
        end else if (deg_eff > 9'd270) begin
            zdeg = zdeg - 11'sd360;
        end

        xv    = IW'(xi_q) <<< SH;
        yv    = IW'(yi_q) <<< SH;
        xs    = x_q >>> i_q;
        ys    = y_q >>> i_q;
        s_pos = mode_q ? y_q[IW-1] : ~z_q[IW-1];

        ang_sum = z_q + (neg_q ? D180 : '0);
        if (ang_sum[IW-1]) ang_sum = ang_sum + D360;
        rz = rne(z_q, ASH);

        case (state_q)
            S_IDLE: begin
                if (bus.start && !done_q) begin
                    mode_d  = bus.mode;
                    deg_d   = bus.degree;
                    xi_d    = bus.x_in;
                    yi_d    = bus.y_in;
                    busy_d  = 1'b1;
                    state_d = S_PRE;
                end
            end
            S_PRE: begin
                if (!mode_q) begin
                    x_d   = INV_K;
                    y_d   = '0;
                    z_d   = IW'(zdeg) <<< ZF;
                    neg_d = neg_rot;
                end else begin
                    neg_d = xi_q[OUT_W-1];
                    x_d   = xi_q[OUT_W-1] ? -xv : xv;
                    y_d   = xi_q[OUT_W-1] ? -yv : yv;
                    z_d   = '0;
                end
                i_d     = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (s_pos) begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - bus.dout;
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + bus.dout;
                end
                if (i_q == LAST) begin
                    i_d     = '0;
                    ph_d    = 1'b0;
                    state_d = S_POST;
                end else begin
                    i_d = i_q + 1'b1;
                end
            end
            S_POST: begin
                // First POST cycle settles sign/offset/gain, second rounds into the outputs.
                if (!ph_q) begin
                    ph_d = 1'b1;
                    if (!mode_q) begin
                        x_d = neg_q ? -x_q : x_q;
                        y_d = neg_q ? -y_q : y_q;
                        z_d = '0;
                    end else begin
`ifdef CORDIC_GAIN_COMP_EN
                        x_d = mag_comp;
`endif
                        y_d = '0;
                        z_d = ang_sum;
                    end
                end else begin
                    res_a_d = sat(rne(x_q, SH));
                    res_b_d = sat(rne(y_q, SH));
                    ang_d   = (rz >= ANG_WRAP) ? 16'd0 : rz[15:0];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ph_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= 1'b0;
            neg_q   <= 1'b0;
            ph_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            deg_q   <= '0;
            xi_q    <= '0;
            yi_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            res_a_q <= '0;
            res_b_q <= '0;
            ang_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            neg_q   <= neg_d;
            ph_q    <= ph_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            deg_q   <= deg_d;
            xi_q    <= xi_d;
            yi_q    <= yi_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            res_a_q <= res_a_d;
            res_b_q <= res_b_d;
            ang_q   <= ang_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.res_a   = res_a_q;
    assign bus.res_b   = res_b_q;
    assign bus.ang_out = ang_q;
    assign bus.addr    = i_q;
endmodule

// File: tb/tb_cordic_multi.sv
// tb/tb_cordic_multi.sv - randomized CORDIC bench against a real-arithmetic trig model
module tb_cordic_multi;
    localparam int ITER     = 16;
    localparam int IW       = 32;
    localparam int OUT_FRAC = 10;
    localparam int AW       = 4;
    localparam int LAT      = ITER + 3;
    localparam real PI      = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int VMAG = 1024;
`else
    localparam int VMAG = 1686;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    real  gain;
    logic signed [IW-1:0] atan_lut [0:ITER-1];

    cordic_multi_if #(.IW(IW), .OUT_FRAC(OUT_FRAC), .AW(AW)) bus ();

    cordic_multi #(.ITER(ITER), .IW(IW), .OUT_FRAC(OUT_FRAC), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.dout = atan_lut[bus.addr];

    task automatic check(input string tag, input int got, input int exp, input int tol = 0);
        checks++;
        if (got - exp > tol || exp - got > tol) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    function automatic int rnd(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    // Ideal results: trig on the folded degree, or polar form of (x, y) with the engine gain.
    task automatic ref_model(input bit m, input int deg, input int xv, input int yv,
                             output int ea, output int eb, output int eang);
        int  d;
        real a;
        if (!m) begin
            d    = (deg >= 360) ? deg - 360 : deg;
            ea   = rnd($cos(real'(d) * PI / 180.0) * 1024.0);
            eb   = rnd($sin(real'(d) * PI / 180.0) * 1024.0);
            eang = 0;
        end else begin
            ea = rnd($sqrt(real'(xv * xv + yv * yv)) * gain);
            eb = 0;
            a  = $atan2(real'(yv), real'(xv)) * 180.0 / PI;
            if (a < 0.0) a = a + 360.0;
            eang = rnd(a * 128.0);
            if (eang >= 46080) eang = eang - 46080;
        end
    endtask

    task automatic run_op(input bit m, input int deg, input int xv, input int yv,
                          input int poke_at, input int rst_at, input bit ign_done,
                          output int ga, output int gb, output int gang, output int cyc);
        int extra;
        ga = 0; gb = 0; gang = 0;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.mode   = m;
        bus.degree = 9'(deg);
        bus.x_in   = 12'(xv);
        bus.y_in   = 12'(yv);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", int'(bus.busy), 0);
                check("rst_done", int'(bus.done), 0);
                check("rst_res_a", int'(bus.res_a), 0);
                check("rst_res_b", int'(bus.res_b), 0);
                check("rst_ang", int'(bus.ang_out), 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            if (bus.done) break;
            if (cyc == 1 || cyc == ITER) check("addr_iter", int'(bus.addr), cyc - 1);
            if (cyc == ITER + 1) check("addr_post", int'(bus.addr), 0);
            if (cyc == poke_at - 1) begin
                bus.start  = 1'b1;
                bus.mode   = ~m;
                bus.degree = 9'd45;
                bus.x_in   = 12'sd300;
                bus.y_in   = -12'sd700;
            end else begin
                bus.start = 1'b0;
            end
        end
        if (!bus.done) begin
            check("done_timeout", 0, 1);
            return;
        end
        ga   = int'(bus.res_a);
        gb   = int'(bus.res_b);
        gang = int'(bus.ang_out);
        if (ign_done) begin
            bus.start  = 1'b1;
            bus.mode   = 1'b0;
            bus.degree = 9'd45;
        end
        extra = 0;
        for (int k = 0; k < ITER + 6; k++) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done) extra++;
            if (k == 0) check("idle_after_done", int'(bus.busy), 0);
        end
        check("extra_done", extra, 0);
    endtask

    task automatic run_and_check(input string tag, input bit m, input int deg,
                                 input int xv, input int yv, input int poke_at, input bit ign_done);
        int ga, gb, gang, cyc, ea, eb, eang;
        ref_model(m, deg, xv, yv, ea, eb, eang);
        run_op(m, deg, xv, yv, poke_at, -1, ign_done, ga, gb, gang, cyc);
        check({tag, "_lat"}, cyc, LAT);
        check({tag, "_a"}, ga, ea, 1);
        check({tag, "_b"}, gb, eb, 1);
        check({tag, "_ang"}, gang, eang, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int dm   [7] = '{0, 0, 0, 0, 1, 1, 1};
        int ddeg [7] = '{0, 90, 210, 359, 0, 0, 0};
        int dx   [7] = '{0, 0, 0, 0, -1024, 0, 724};
        int dy   [7] = '{0, 0, 0, 0, 0, -1024, 724};
        int da   [7] = '{1024, 0, -887, 1024, VMAG, VMAG, VMAG};
        int db   [7] = '{0, 1024, -512, -18, 0, 0, 0};
        int dang [7] = '{0, 0, 0, 0, 23040, 34560, 5760};
        int ga, gb, gang, cyc, ea, eb, eang, xv, yv, tries;
        bit m;

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.degree = '0;
        bus.x_in   = '0;
        bus.y_in   = '0;
        for (int i = 0; i < ITER; i++)
            atan_lut[i] = $rtoi($atan(2.0 ** (-i)) * 180.0 / PI * (2.0 ** (IW - 10)) + 0.5);
`ifdef CORDIC_GAIN_COMP_EN
        gain = 1.0;
`else
        gain = 1.0;
        for (int i = 0; i < ITER; i++) gain = gain * $sqrt(1.0 + 2.0 ** (-2 * i));
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_res_a", int'(bus.res_a), 0);
        check("reset_res_b", int'(bus.res_b), 0);
        check("reset_ang", int'(bus.ang_out), 0);
        check("reset_addr", int'(bus.addr), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            run_op(dm[t][0], ddeg[t], dx[t], dy[t], -1, -1, 1'b0, ga, gb, gang, cyc);
            check("dir_lat", cyc, LAT);
            check("dir_a", ga, da[t], 1);
            check("dir_b", gb, db[t], 1);
            check("dir_ang", gang, dang[t], 1);
        end

        run_and_check("deg270", 1'b0, 270, 0, 0, -1, 1'b0);
        run_and_check("deg360", 1'b0, 360, 0, 0, -1, 1'b0);
        run_and_check("deg511", 1'b0, 511, 0, 0, -1, 1'b0);
        run_and_check("vec_min", 1'b1, 0, -2048, -2048, -1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            m = 1'($urandom_range(0, 1));
            if (!m) begin
                run_and_check("rnd_rot", 1'b0, int'($urandom_range(0, 511)), 0, 0, -1, 1'b0);
            end else begin
                tries = 0;
                do begin
                    xv = int'($urandom_range(0, 4095)) - 2048;
                    yv = int'($urandom_range(0, 4095)) - 2048;
                    ref_model(1'b1, 0, xv, yv, ea, eb, eang);
                    tries++;
                end while (tries < 100 &&
                           (xv * xv + yv * yv < 65536 || eang < 8 || eang > 46072));
                run_and_check("rnd_vec", 1'b1, 0, xv, yv, -1, 1'b0);
            end
        end

        run_and_check("poke_t5", 1'b0, 60, 0, 0, 5, 1'b0);
        run_and_check("done_cyc_start", 1'b1, 0, 500, -300, -1, 1'b1);
        run_and_check("back_to_back", 1'b0, 135, 0, 0, -1, 1'b0);

        run_op(1'b0, 120, 0, 0, -1, 8, 1'b0, ga, gb, gang, cyc);
        check("rst_abort_cyc", cyc, 8);
        run_op(1'b0, 30, 0, 0, -1, -1, 1'b0, ga, gb, gang, cyc);
        check("after_rst_lat", cyc, LAT);
        check("after_rst_a", ga, 887, 1);
        check("after_rst_b", gb, 512, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
